// File: rtl/ob_cmd_arb.sv
// Order-book command arbiter: per-port one-entry holding registers, round-robin
// issue onto the registered ob command bus, and tag-based response demux.
package ob_pkg;
    localparam int UID_W = 12;

    typedef enum logic [1:0] {
        Op_Nop    = 2'd0,
        Op_Buy    = 2'd1,
        Op_Sell   = 2'd2,
        Op_Cancel = 2'd3
    } opcode_t;

    typedef struct packed {
        opcode_t          opcode;
        logic [UID_W-1:0] uid;
        logic [15:0]      oprand;
    } cmd_t;

    typedef struct packed {
        logic [UID_W-1:0] uid;
        logic [7:0]       status;
    } rsp_t;
endpackage

// One-entry holding register for a single requester port.
module ob_cmd_arb_slot (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  ob_pkg::cmd_t  in_cmd,
    input  logic          take,
    output logic          hold_vld,
    output ob_pkg::cmd_t  hold,
    output logic          in_rdy
);
    logic fill;

    assign in_rdy = !hold_vld | take;
    // Nops complete the handshake but never occupy the slot.
    assign fill   = in_vld & in_rdy & (in_cmd.opcode != ob_pkg::Op_Nop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld <= 1'b0;
            hold     <= '0;
        end else if (fill) begin
            hold_vld <= 1'b1;
            hold     <= in_cmd;
        end else if (take) begin
            hold_vld <= 1'b0;
        end
    end
endmodule

module ob_cmd_arb #(
    parameter  int N_PORTS = 4,
    localparam int PORT_W  = $clog2(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            cfg_port_en,
    input  logic [N_PORTS-1:0]            in_vld,
    input  ob_pkg::cmd_t [N_PORTS-1:0]    in_cmd,
    output logic [N_PORTS-1:0]            in_rdy,
    output logic                          cmd_vld_r,
    output ob_pkg::cmd_t                  cmd_r,
    input  logic                          cmd_full_r,
    input  logic                          rsp_vld,
    input  ob_pkg::rsp_t                  rsp,
    output logic                          rsp_accept,
    output logic [N_PORTS-1:0]            out_rsp_vld,
    output ob_pkg::rsp_t                  out_rsp,
    input  logic [N_PORTS-1:0]            out_rsp_accept,
    output logic                          err_bad_tag_r
);
    localparam int UID_W = ob_pkg::UID_W;

    logic [N_PORTS-1:0]         hold_vld;
    ob_pkg::cmd_t [N_PORTS-1:0] hold;
    logic [N_PORTS-1:0]         eligible;
    logic [N_PORTS-1:0]         grant;
    logic [PORT_W-1:0]          grant_idx;
    logic [PORT_W-1:0]          rr_ptr;
    logic                       found;
    logic                       issue;
    ob_pkg::cmd_t               issue_cmd;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_slot
        ob_cmd_arb_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .in_vld   (in_vld[i]),
            .in_cmd   (in_cmd[i]),
            .take     (grant[i] & issue),
            .hold_vld (hold_vld[i]),
            .hold     (hold[i]),
            .in_rdy   (in_rdy[i])
        );
    end

    assign eligible = hold_vld & cfg_port_en;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            logic [PORT_W-1:0] idx;
            idx = PORT_W'((int'(rr_ptr) + k) % N_PORTS);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found) grant[grant_idx] = 1'b1;
    end

    assign issue = found & !cmd_full_r;

    always_comb begin
        issue_cmd = hold[grant_idx];
        issue_cmd.uid[UID_W-1 -: PORT_W] = grant_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_vld_r <= 1'b0;
            cmd_r     <= '0;
            rr_ptr    <= '0;
        end else begin
            cmd_vld_r <= issue;
            if (issue) begin
                cmd_r  <= issue_cmd;
                rr_ptr <= (grant_idx == PORT_W'(N_PORTS - 1)) ? '0 : grant_idx + PORT_W'(1);
            end
        end
    end

    logic [PORT_W-1:0] dest;
    logic              bad_tag;

    assign dest    = rsp.uid[UID_W-1 -: PORT_W];
    assign out_rsp = rsp;

    // Out-of-range tags only exist when N_PORTS is not a power of two.
    if ((1 << PORT_W) > N_PORTS) begin : g_bad
        assign bad_tag = dest > PORT_W'(N_PORTS - 1);
    end else begin : g_nobad
        assign bad_tag = 1'b0;
    end

    always_comb begin
        rsp_accept  = bad_tag;
        out_rsp_vld = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (dest == PORT_W'(k)) begin
                rsp_accept     = out_rsp_accept[k];
                out_rsp_vld[k] = rsp_vld;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   err_bad_tag_r <= 1'b0;
        else if (rsp_vld & bad_tag) err_bad_tag_r <= 1'b1;
    end
endmodule

// File: tb/tb_ob_cmd_arb.sv
// Directed bench for ob_cmd_arb: a 4-port instance for arbitration and response
// demux, and a 3-port instance for the out-of-range response tag.
module tb_ob_cmd_arb;
    import ob_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       cfg_port_en = 4'hf;
    logic [3:0]       in_vld = '0;
    cmd_t [3:0]       in_cmd = '0;
    logic [3:0]       in_rdy;
    logic             cmd_vld_r;
    cmd_t             cmd_r;
    logic             cmd_full_r = 1'b0;
    logic             rsp_vld = 1'b0;
    rsp_t             rsp = '0;
    logic             rsp_accept;
    logic [3:0]       out_rsp_vld;
    rsp_t             out_rsp;
    logic [3:0]       out_rsp_accept = '0;
    logic             err_bad_tag_r;

    logic [2:0]       in_vld3 = '0;
    cmd_t [2:0]       in_cmd3 = '0;
    logic [2:0]       in_rdy3;
    logic             cmd_vld_r3;
    cmd_t             cmd_r3;
    logic             rsp_vld3 = 1'b0;
    rsp_t             rsp3 = '0;
    logic             rsp_accept3;
    logic [2:0]       out_rsp_vld3;
    rsp_t             out_rsp3;
    logic             err3;

    ob_cmd_arb #(.N_PORTS(4)) dut (
        .clk(clk), .rst(rst), .cfg_port_en(cfg_port_en),
        .in_vld(in_vld), .in_cmd(in_cmd), .in_rdy(in_rdy),
        .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(cmd_full_r),
        .rsp_vld(rsp_vld), .rsp(rsp), .rsp_accept(rsp_accept),
        .out_rsp_vld(out_rsp_vld), .out_rsp(out_rsp),
        .out_rsp_accept(out_rsp_accept), .err_bad_tag_r(err_bad_tag_r)
    );

    ob_cmd_arb #(.N_PORTS(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_port_en(3'b111),
        .in_vld(in_vld3), .in_cmd(in_cmd3), .in_rdy(in_rdy3),
        .cmd_vld_r(cmd_vld_r3), .cmd_r(cmd_r3), .cmd_full_r(1'b0),
        .rsp_vld(rsp_vld3), .rsp(rsp3), .rsp_accept(rsp_accept3),
        .out_rsp_vld(out_rsp_vld3), .out_rsp(out_rsp3),
        .out_rsp_accept(3'b000), .err_bad_tag_r(err3)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cmd_t mk(input opcode_t op, input logic [11:0] uid, input logic [15:0] qty);
        cmd_t c;
        c.opcode = op;
        c.uid    = uid;
        c.oprand = qty;
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #2;
        chk("rst_cmd_vld", cmd_vld_r, 0);
        chk("rst_cmd_r", cmd_r, 0);
        chk("rst_in_rdy", in_rdy, 4'hf);
        chk("rst_err", err_bad_tag_r, 0);
        rst = 1'b1;
        tick();
        tick();

        // single command: handshake cycle t, visible at t+2, one pulse
        in_vld[0] = 1'b1;
        in_cmd[0] = mk(Op_Buy, 12'h005, 16'd10);
        tick();
        in_vld = '0;
        chk("lat_t1", cmd_vld_r, 0);
        tick();
        chk("lat_t2_vld", cmd_vld_r, 1);
        chk("lat_t2_cmd", cmd_r, mk(Op_Buy, 12'h005, 16'd10));
        tick();
        chk("lat_pulse", cmd_vld_r, 0);

        // round robin with all ports continuously refilling
        do_reset();
        in_vld = 4'hf;
        for (int p = 0; p < 4; p++) in_cmd[p] = mk(Op_Sell, 12'(12'h011 * (p + 1)), 16'(p));
        tick();
        chk("rr_rdy", in_rdy, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rr_vld%0d", i), cmd_vld_r, 1);
            chk($sformatf("rr_uid%0d", i), cmd_r.uid,
                12'(((i % 4) << 10) | (12'h011 * ((i % 4) + 1))));
        end
        in_vld = '0;

        // asynchronous reset mid-stream with held commands
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", cmd_vld_r, 0);
        chk("mid_rst_rdy", in_rdy, 4'hf);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst%0d", i), cmd_vld_r, 0);
        end

        // back-pressure on a held command
        cmd_full_r = 1'b1;
        in_vld[1]  = 1'b1;
        in_cmd[1]  = mk(Op_Cancel, 12'h077, 16'd3);
        tick();
        in_vld = '0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_vld%0d", i), cmd_vld_r, 0);
            chk($sformatf("full_rdy%0d", i), in_rdy[1], 0);
            tick();
        end
        cmd_full_r = 1'b0;
        #1;
        chk("full_rel_rdy", in_rdy[1], 1);
        tick();
        chk("full_rel_vld", cmd_vld_r, 1);
        chk("full_rel_uid", cmd_r.uid, 12'h477);
        chk("full_after_rdy", in_rdy[1], 1);

        // disabled port keeps its command (rr_ptr is now 2)
        cfg_port_en = 4'b1101;
        in_vld      = 4'b0110;
        in_cmd[1]   = mk(Op_Buy, 12'h0a1, 16'd7);
        in_cmd[2]   = mk(Op_Sell, 12'h0b2, 16'd8);
        tick();
        in_vld = '0;
        chk("dis_rdy", in_rdy, 4'b1101);
        tick();
        chk("dis_vld", cmd_vld_r, 1);
        chk("dis_uid2", cmd_r.uid, 12'h8b2);
        tick();
        chk("dis_idle", cmd_vld_r, 0);
        chk("dis_held_rdy", in_rdy[1], 0);
        cfg_port_en = 4'hf;
        tick();
        chk("reen_vld", cmd_vld_r, 1);
        chk("reen_cmd", cmd_r, mk(Op_Buy, 12'h4a1, 16'd7));

        // Nop is accepted and dropped
        in_vld[3] = 1'b1;
        in_cmd[3] = mk(Op_Nop, 12'h033, 16'd0);
        #1;
        chk("nop_rdy", in_rdy[3], 1);
        tick();
        in_vld = '0;
        chk("nop_vld1", cmd_vld_r, 0);
        chk("nop_not_held", in_rdy, 4'hf);
        tick();
        chk("nop_vld2", cmd_vld_r, 0);

        // response demux with accept back-pressure
        rsp_vld = 1'b1;
        rsp     = '{uid: 12'h833, status: 8'h5a};
        out_rsp_accept = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rsp_vld%0d", i), out_rsp_vld, 4'b0100);
            chk($sformatf("rsp_acc%0d", i), rsp_accept, 0);
            tick();
        end
        out_rsp_accept = 4'b0100;
        #1;
        chk("rsp_vld3", out_rsp_vld, 4'b0100);
        chk("rsp_acc3", rsp_accept, 1);
        chk("rsp_bus", out_rsp, 20'h8335a);
        tick();
        rsp_vld = 1'b0;
        #1;
        chk("rsp_idle", out_rsp_vld, 4'b0000);
        chk("rsp_no_err", err_bad_tag_r, 0);

        // out-of-range tag on the 3-port instance
        rsp_vld3 = 1'b1;
        rsp3     = '{uid: 12'h405, status: 8'h01};
        #1;
        chk("n3_good_vld", out_rsp_vld3, 3'b010);
        chk("n3_good_acc", rsp_accept3, 0);
        rsp3 = '{uid: 12'hc05, status: 8'h02};
        #1;
        chk("n3_bad_acc", rsp_accept3, 1);
        chk("n3_bad_vld", out_rsp_vld3, 3'b000);
        chk("n3_err_pre", err3, 0);
        tick();
        rsp_vld3 = 1'b0;
        chk("n3_err_set", err3, 1);
        tick();
        tick();
        chk("n3_err_sticky", err3, 1);
        rst = 1'b0;
        #1;
        chk("n3_err_clr", err3, 0);
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
